// File: rtl/sr_7seg_mux_scan_driver.sv
// +----------------------------------------------------------------------------+
// | sr_7seg_mux_scan_driver                                                    |
// | Multiplexed 7-segment scanner driving a 74HC595 chain with per-digit PWM.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sr_7seg_mux_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int SEG_W          = 8,
  parameter int BRIGHT_W       = 8,
  parameter int SCLK_DIV       = 6,
  parameter int DWELL_PRESCALE = 2,
  parameter int BLINK_W        = 6,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clear_buffer,
  input  logic                       commit_char,
  input  logic [$clog2(DIGITS)-1:0]  char_sel,
  input  logic [SEG_W-1:0]           seg_data,
  input  logic [BRIGHT_W-1:0]        char_bright,
  input  logic                       char_blink,
  output logic                       SCLK,
  output logic                       DOUT,
  output logic                       RCLK,
  output logic                       OE,
  output logic                       frame_start
);

  localparam int C_IDX_W = $clog2(DIGITS);
  localparam int C_N     = DIGITS + SEG_W;
  localparam int C_BIT_W = $clog2(C_N);
  localparam int C_DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int C_PRE_W = (DWELL_PRESCALE > 1) ? $clog2(DWELL_PRESCALE) : 1;

  localparam logic [C_DIV_W-1:0]  C_DIV_LAST   = C_DIV_W'(SCLK_DIV - 1);
  localparam logic [C_PRE_W-1:0]  C_PRE_LAST   = C_PRE_W'(DWELL_PRESCALE - 1);
  localparam logic [C_BIT_W-1:0]  C_BIT_LAST   = C_BIT_W'(C_N - 1);
  localparam logic [C_IDX_W-1:0]  C_DIGIT_LAST = C_IDX_W'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] C_TICK_LAST  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_LATCH = 3'd3,
    S_DWELL = 3'd4
  } state_t;

  logic [SEG_W-1:0]    r_seg_buf    [DIGITS];
  logic [BRIGHT_W-1:0] r_bright_buf [DIGITS];
  logic [DIGITS-1:0]   r_blink_buf;

  state_t              r_state;
  logic [C_IDX_W-1:0]  r_digit;
  logic [BLINK_W-1:0]  r_frame_cnt;
  logic [C_N-1:0]      r_shreg;
  logic [C_BIT_W-1:0]  r_bit_cnt;
  logic [C_DIV_W-1:0]  r_div_cnt;
  logic [C_PRE_W-1:0]  r_pre_cnt;
  logic [BRIGHT_W-1:0] r_tick;
  logic [BRIGHT_W-1:0] r_cur_bright;
  logic                r_cur_blank;

  logic [DIGITS-1:0]   w_onehot;
  logic [DIGITS-1:0]   w_sel;
  logic [C_N-1:0]      w_word;
  logic [C_IDX_W-1:0]  w_digit_nxt;
  logic [BRIGHT_W-1:0] w_tick_nxt;
  logic                w_lit_nxt;

  // Clear has priority over a same-cycle commit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_seg_buf[i]    <= '0;
        r_bright_buf[i] <= '0;
      end
      r_blink_buf <= '0;
    end else if (clear_buffer) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_seg_buf[i]    <= '0;
        r_bright_buf[i] <= '0;
      end
      r_blink_buf <= '0;
    end else if (commit_char) begin
      r_seg_buf[char_sel]    <= seg_data;
      r_bright_buf[char_sel] <= char_bright;
      r_blink_buf[char_sel]  <= char_blink;
    end
  end

  always_comb begin
    w_onehot          = '0;
    w_onehot[r_digit] = 1'b1;
    w_sel             = (SEL_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    w_word            = {w_sel, r_seg_buf[r_digit]};
    w_digit_nxt       = r_digit + C_IDX_W'(1);
    w_tick_nxt        = r_tick + BRIGHT_W'(1);
    w_lit_nxt         = (w_tick_nxt < r_cur_bright) && !r_cur_blank;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_digit      <= '0;
      r_frame_cnt  <= '0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_pre_cnt    <= '0;
      r_tick       <= '0;
      r_cur_bright <= '0;
      r_cur_blank  <= 1'b0;
      SCLK         <= 1'b0;
      DOUT         <= 1'b0;
      RCLK         <= 1'b0;
      OE           <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!en) begin
        r_state <= S_IDLE;
        r_digit <= '0;
        SCLK    <= 1'b0;
        DOUT    <= 1'b0;
        RCLK    <= 1'b0;
        OE      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state     <= S_LOAD;
            r_digit     <= '0;
            frame_start <= 1'b1;
          end
          // Snapshot the entry here so later writes cannot tear this visit.
          S_LOAD: begin
            DOUT         <= w_word[C_N-1];
            r_shreg      <= w_word << 1;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            SCLK         <= 1'b0;
            r_cur_bright <= r_bright_buf[r_digit];
            r_cur_blank  <= r_blink_buf[r_digit] & r_frame_cnt[BLINK_W-1];
            r_state      <= S_SHIFT;
          end
          S_SHIFT: begin
            if (r_div_cnt != C_DIV_LAST) begin
              r_div_cnt <= r_div_cnt + C_DIV_W'(1);
            end else begin
              r_div_cnt <= '0;
              if (!SCLK) begin
                SCLK <= 1'b1;
              end else begin
                SCLK <= 1'b0;
                if (r_bit_cnt == C_BIT_LAST) begin
                  DOUT    <= 1'b0;
                  RCLK    <= 1'b1;
                  r_state <= S_LATCH;
                end else begin
                  r_bit_cnt <= r_bit_cnt + C_BIT_W'(1);
                  DOUT      <= r_shreg[C_N-1];
                  r_shreg   <= r_shreg << 1;
                end
              end
            end
          end
          S_LATCH: begin
            if (r_div_cnt != C_DIV_LAST) begin
              r_div_cnt <= r_div_cnt + C_DIV_W'(1);
            end else begin
              r_div_cnt <= '0;
              RCLK      <= 1'b0;
              r_tick    <= '0;
              r_pre_cnt <= '0;
              OE        <= !((r_cur_bright != '0) && !r_cur_blank);
              r_state   <= S_DWELL;
            end
          end
          // OE for the coming tick is decided one cycle ahead so it stays registered.
          S_DWELL: begin
            if (r_pre_cnt != C_PRE_LAST) begin
              r_pre_cnt <= r_pre_cnt + C_PRE_W'(1);
            end else begin
              r_pre_cnt <= '0;
              if (r_tick == C_TICK_LAST) begin
                OE          <= 1'b1;
                r_state     <= S_LOAD;
                r_digit     <= w_digit_nxt;
                frame_start <= (w_digit_nxt == '0);
                if (r_digit == C_DIGIT_LAST) begin
                  r_frame_cnt <= r_frame_cnt + BLINK_W'(1);
                end
              end else begin
                r_tick <= w_tick_nxt;
                OE     <= !w_lit_nxt;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_7seg_mux_scan_driver.sv
// +----------------------------------------------------------------------------+
// | tb_sr_7seg_mux_scan_driver                                                 |
// | Self-checking bench: per-digit scan records against a buffer/frame model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sr_7seg_mux_scan_driver;

  localparam int N      = 12;
  localparam int DWELL  = 16;
  localparam int PERIOD = 42;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0, en = 1'b0, clear_buffer = 1'b0, commit_char = 1'b0;
  logic [1:0] char_sel = '0;
  logic [7:0] seg_data = '0;
  logic [3:0] char_bright = '0;
  logic       char_blink = 1'b0;
  logic sclk_a, dout_a, rclk_a, oe_a, fs_a;
  logic sclk_b, dout_b, rclk_b, oe_b, fs_b;

  always #5 sys_clk = ~sys_clk;

  sr_7seg_mux_scan_driver #(.DIGITS(4), .SEG_W(8), .BRIGHT_W(4), .SCLK_DIV(1),
    .DWELL_PRESCALE(1), .BLINK_W(2), .SEL_ACTIVE_LOW(0)) dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .clear_buffer(clear_buffer),
    .commit_char(commit_char), .char_sel(char_sel), .seg_data(seg_data),
    .char_bright(char_bright), .char_blink(char_blink), .SCLK(sclk_a),
    .DOUT(dout_a), .RCLK(rclk_a), .OE(oe_a), .frame_start(fs_a));

  sr_7seg_mux_scan_driver #(.DIGITS(4), .SEG_W(8), .BRIGHT_W(4), .SCLK_DIV(1),
    .DWELL_PRESCALE(1), .BLINK_W(2), .SEL_ACTIVE_LOW(1)) dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .clear_buffer(clear_buffer),
    .commit_char(commit_char), .char_sel(char_sel), .seg_data(seg_data),
    .char_bright(char_bright), .char_blink(char_blink), .SCLK(sclk_b),
    .DOUT(dout_b), .RCLK(rclk_b), .OE(oe_b), .frame_start(fs_b));

  int tests = 0;
  int fails = 0;

  // Reference model: buffer contents plus scan position.
  logic [7:0] ref_seg [4];
  logic [3:0] ref_br  [4];
  bit         ref_bk  [4];
  int         ref_digit = 0;
  int         ref_frame = 0;

  function automatic logic [11:0] exp_word(int d);
    logic [3:0] s;
    s = 4'(1 << d);
    return {s, ref_seg[d]};
  endfunction

  function automatic int exp_on(int d);
    if (ref_bk[d] && (ref_frame % 4) >= 2) return 0;
    return int'(ref_br[d]);
  endfunction

  task automatic model_advance();
    if (ref_digit == 3) ref_frame++;
    ref_digit = (ref_digit + 1) % 4;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      ref_seg[i] = '0; ref_br[i] = '0; ref_bk[i] = 1'b0;
    end
  endtask

  // Monitor: one record per completed digit visit (shift, latch, full dwell).
  typedef struct {
    logic [11:0] word;
    int nbits; int rclen; int oe_low; int fs_cnt; int t_rclk; int stray;
  } rec_t;
  rec_t q[$];

  logic [11:0] mon_sh;
  int mon_nb, mon_rc, mon_oel, mon_dc, mon_fs, mon_trc, mon_stray, cyc;
  bit mon_dwell;
  logic mon_psclk, mon_prclk;

  always @(negedge sys_clk) begin
    cyc++;
    if (!rst_n || !en) begin
      mon_sh = '0; mon_nb = 0; mon_rc = 0; mon_oel = 0; mon_dc = 0; mon_fs = 0;
      mon_stray = 0; mon_dwell = 1'b0; mon_psclk = 1'b0; mon_prclk = 1'b0;
    end else begin
      if (fs_a) mon_fs++;
      if (sclk_a && !mon_psclk) begin mon_sh = {mon_sh[10:0], dout_a}; mon_nb++; end
      if (rclk_a) begin mon_rc++; if (!mon_prclk) mon_trc = cyc; end
      if (!rclk_a && mon_prclk) begin mon_dwell = 1'b1; mon_dc = 0; mon_oel = 0; end
      if (mon_dwell) begin
        if (!oe_a) mon_oel++;
        mon_dc++;
        if (mon_dc == DWELL) begin
          q.push_back('{word: mon_sh, nbits: mon_nb, rclen: mon_rc, oe_low: mon_oel,
                        fs_cnt: mon_fs, t_rclk: mon_trc, stray: mon_stray});
          mon_sh = '0; mon_nb = 0; mon_rc = 0; mon_fs = 0; mon_stray = 0; mon_dwell = 1'b0;
        end
      end else if (!oe_a) begin
        mon_stray++;
      end
      mon_psclk = sclk_a;
      mon_prclk = rclk_a;
    end
  end

  logic q2[$];
  logic mon2_psclk;
  always @(negedge sys_clk) begin
    if (!rst_n || !en) begin
      q2.delete(); mon2_psclk = 1'b0;
    end else begin
      if (sclk_b && !mon2_psclk) q2.push_back(dout_b);
      mon2_psclk = sclk_b;
    end
  end

  task automatic get_rec(output rec_t r, output bit ok);
    int n;
    n = 0;
    r = '{word: '0, nbits: 0, rclen: 0, oe_low: 0, fs_cnt: 0, t_rclk: 0, stray: 0};
    while (q.size() == 0 && n < 200) begin @(negedge sys_clk); n++; end
    ok = (q.size() != 0);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL get_rec: scans seen 0 after %0d cycles, need 1", n);
    end else begin
      r = q.pop_front();
    end
  endtask

  task automatic write_entry(int idx, logic [7:0] s, logic [3:0] b, bit k);
    @(posedge sys_clk); #2;
    commit_char = 1'b1; char_sel = 2'(idx); seg_data = s; char_bright = b; char_blink = k;
    @(posedge sys_clk); #2;
    commit_char = 1'b0;
    ref_seg[idx] = s; ref_br[idx] = b; ref_bk[idx] = k;
  endtask

  task automatic set_en(bit v);
    @(posedge sys_clk); #2;
    en = v;
    if (v) begin
      ref_digit = 0;
    end else begin
      @(posedge sys_clk); @(negedge sys_clk); #1;
      while (q.size() != 0) begin void'(q.pop_front()); model_advance(); end
    end
  endtask

  task automatic test_reset();
    rec_t r; bit ok; int d;
    model_clear();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    tests++;
    if ({oe_a, sclk_a, rclk_a, dout_a, fs_a} !== 5'b10000) begin
      fails++; $display("FAIL reset_state: got %b need 10000", {oe_a, sclk_a, rclk_a, dout_a, fs_a});
    end
    @(posedge sys_clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) write_entry(i, 8'($urandom), 4'($urandom_range(1, 15)), 1'b0);
    set_en(1'b1);
    repeat ($urandom_range(5, 35)) @(posedge sys_clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({oe_a, sclk_a, rclk_a, dout_a, fs_a} !== 5'b10000) begin
      fails++; $display("FAIL reset_async: got %b need 10000", {oe_a, sclk_a, rclk_a, dout_a, fs_a});
    end
    model_clear(); ref_frame = 0; q.delete();
    @(posedge sys_clk); #2 rst_n = 1'b1; ref_digit = 0;
    for (int i = 0; i < 4; i++) begin
      get_rec(r, ok); if (!ok) break;
      d = ref_digit;
      tests++;
      if (r.word !== exp_word(d) || r.nbits != N || r.oe_low != exp_on(d)) begin
        fails++; $display("FAIL reset_dark d%0d: got %03h/%0d bits/%0d on, need %03h/12/%0d",
                          d, r.word, r.nbits, r.oe_low, exp_word(d), exp_on(d));
      end
      model_advance();
    end
  endtask

  task automatic test_single_digit();
    rec_t r; bit ok;
    set_en(1'b0);
    write_entry(0, 8'hA5, 4'd15, 1'b0);
    set_en(1'b1);
    get_rec(r, ok);
    if (ok) begin
      tests++;
      if (r.word !== 12'b0001_1010_0101 || r.nbits != N) begin
        fails++; $display("FAIL single_word: got %03h/%0d bits need 1a5/12", r.word, r.nbits);
      end
      tests++;
      if (r.oe_low != 15) begin fails++; $display("FAIL single_oe: got %0d on-ticks need 15", r.oe_low); end
      tests++;
      if (r.rclen != 1 || r.fs_cnt != 1 || r.stray != 0) begin
        fails++; $display("FAIL single_ctrl: rclk %0d fs %0d stray %0d, need 1 1 0", r.rclen, r.fs_cnt, r.stray);
      end
      model_advance();
    end
    set_en(1'b0);
  endtask

  task automatic test_dimming();
    rec_t r; bit ok; int d; int prev_t;
    prev_t = 0;
    write_entry(1, 8'($urandom), 4'($urandom), 1'b0);
    write_entry(2, 8'($urandom), 4'd0, 1'b0);
    write_entry(3, 8'($urandom), 4'd8, 1'b0);
    set_en(1'b1);
    for (int i = 0; i < 4; i++) begin
      get_rec(r, ok); if (!ok) break;
      d = ref_digit;
      tests++;
      if (r.word !== exp_word(d) || r.nbits != N) begin
        fails++; $display("FAIL dim_word d%0d: got %03h/%0d need %03h/12", d, r.word, r.nbits, exp_word(d));
      end
      tests++;
      if (r.oe_low != exp_on(d)) begin
        fails++; $display("FAIL dim_oe d%0d: got %0d on-ticks need %0d", d, r.oe_low, exp_on(d));
      end
      tests++;
      if (r.rclen != 1 || r.stray != 0 || r.fs_cnt != int'(d == 0)) begin
        fails++; $display("FAIL dim_ctrl d%0d: rclk %0d stray %0d fs %0d", d, r.rclen, r.stray, r.fs_cnt);
      end
      if (i > 0) begin
        tests++;
        if (r.t_rclk - prev_t != PERIOD) begin
          fails++; $display("FAIL dim_spacing d%0d: got %0d cycles need %0d", d, r.t_rclk - prev_t, PERIOD);
        end
      end
      prev_t = r.t_rclk;
      model_advance();
    end
    set_en(1'b0);
  endtask

  task automatic test_blink();
    rec_t r; bit ok; int d;
    @(posedge sys_clk); #2 rst_n = 1'b0;
    @(posedge sys_clk); #2 rst_n = 1'b1;
    model_clear(); ref_frame = 0; q.delete();
    write_entry(0, 8'($urandom), 4'($urandom), 1'b0);
    write_entry(1, 8'($urandom), 4'd15, 1'b1);
    write_entry(2, 8'($urandom), 4'($urandom), 1'b0);
    write_entry(3, 8'($urandom), 4'($urandom), 1'b0);
    set_en(1'b1);
    for (int i = 0; i < 20; i++) begin
      get_rec(r, ok); if (!ok) break;
      d = ref_digit;
      tests++;
      if (r.word !== exp_word(d) || r.oe_low != exp_on(d)) begin
        fails++; $display("FAIL blink f%0d d%0d: got %03h/%0d on, need %03h/%0d",
                          ref_frame, d, r.word, r.oe_low, exp_word(d), exp_on(d));
      end
      model_advance();
    end
    set_en(1'b0);
  endtask

  task automatic test_clear_wins();
    rec_t r; bit ok; int d;
    @(posedge sys_clk); #2;
    commit_char = 1'b1; clear_buffer = 1'b1; char_sel = 2'd1; seg_data = 8'hFF;
    char_bright = 4'd15; char_blink = 1'b0;
    @(posedge sys_clk); #2;
    commit_char = 1'b0; clear_buffer = 1'b0;
    model_clear();
    set_en(1'b1);
    for (int i = 0; i < 4; i++) begin
      get_rec(r, ok); if (!ok) break;
      d = ref_digit;
      tests++;
      if (r.word !== exp_word(d) || r.oe_low != exp_on(d)) begin
        fails++; $display("FAIL clear_wins d%0d: got %03h/%0d on, need %03h/%0d",
                          d, r.word, r.oe_low, exp_word(d), exp_on(d));
      end
      model_advance();
    end
    set_en(1'b0);
  endtask

  task automatic test_en_drop();
    rec_t r; bit ok; int d; int n; logic [11:0] got2; logic [3:0] sel0;
    for (int i = 0; i < 4; i++) write_entry(i, 8'($urandom), 4'($urandom), 1'($urandom));
    set_en(1'b1);
    for (int i = 0; i < 2; i++) begin
      get_rec(r, ok); if (!ok) break;
      d = ref_digit;
      tests++;
      if (r.word !== exp_word(d) || r.oe_low != exp_on(d)) begin
        fails++; $display("FAIL drop_pre d%0d: got %03h/%0d on, need %03h/%0d",
                          d, r.word, r.oe_low, exp_word(d), exp_on(d));
      end
      model_advance();
    end
    n = 0;
    while (sclk_a !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
    @(posedge sys_clk); #2 en = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    tests++;
    if ({oe_a, sclk_a, rclk_a, dout_a, fs_a, oe_b, sclk_b, rclk_b, dout_b} !== 9'b100001000) begin
      fails++; $display("FAIL drop_idle: got %b need 100001000",
                        {oe_a, sclk_a, rclk_a, dout_a, fs_a, oe_b, sclk_b, rclk_b, dout_b});
    end
    q.delete();
    repeat (10) @(posedge sys_clk);
    #2 en = 1'b1; ref_digit = 0;
    get_rec(r, ok);
    if (ok) begin
      tests++;
      if (r.word !== exp_word(0) || r.fs_cnt != 1 || r.oe_low != exp_on(0)) begin
        fails++; $display("FAIL drop_restart: got %03h fs %0d on %0d, need %03h fs 1 on %0d",
                          r.word, r.fs_cnt, r.oe_low, exp_word(0), exp_on(0));
      end
      model_advance();
    end
    n = 0;
    while (q2.size() < 12 && n < 100) begin @(negedge sys_clk); n++; end
    got2 = '0;
    if (q2.size() >= 12) for (int i = 0; i < 12; i++) got2 = {got2[10:0], q2[i]};
    sel0 = 4'b0001;
    tests++;
    if (got2 !== {~sel0, ref_seg[0]}) begin
      fails++; $display("FAIL sel_active_low: got %03h need %03h", got2, {~sel0, ref_seg[0]});
    end
    set_en(1'b0);
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_dimming();
    test_blink();
    test_clear_wins();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
